rx_decrypt_scheduler: RTL and testbench

Frame-level controller for the receiver decrypt path. Walks the encrypted R/G/B pixel memories address by address and shares the single chaotic-LFSR keystream generator among the three colour channels, requesting keystream bytes in R, G, B order. Writes the XOR-decrypted pixel into the decrypted-channel memories and signals `done` once the whole frame has been written. It sits in the receiver top level between the generator instance and the channel memories, replacing free-running decrypt sequencing.

---
 rtl/rx_decrypt_scheduler_if.sv | 37 +++
 rtl/rx_decrypt_scheduler.sv | 130 +++++++++++++
 tb/tb_rx_decrypt_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_decrypt_scheduler_if.sv
// rtl/rx_decrypt_scheduler_if.sv - keystream, encrypted-read and decrypted-write bus bundle
interface rx_decrypt_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // keystream generator handshake
    logic              prng_seed_load;
    logic              prng_req;
    logic              prng_valid;
    logic [DATA_W-1:0] prng_byte;

    // encrypted channel memories, read data one cycle after rd_en
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_r;
    logic [DATA_W-1:0] rd_data_g;
    logic [DATA_W-1:0] rd_data_b;

    // decrypted channel memories
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] wr_data_g;
    logic [DATA_W-1:0] wr_data_b;

    modport master (
        output prng_seed_load, prng_req, rd_en, rd_addr,
               wr_en, wr_addr, wr_data_r, wr_data_g, wr_data_b,
        input  prng_valid, prng_byte, rd_data_r, rd_data_g, rd_data_b
    );

    modport slave (
        input  prng_seed_load, prng_req, rd_en, rd_addr,
               wr_en, wr_addr, wr_data_r, wr_data_g, wr_data_b,
        output prng_valid, prng_byte, rd_data_r, rd_data_g, rd_data_b
    );
endinterface

// File: rtl/rx_decrypt_scheduler.sv
// rtl/rx_decrypt_scheduler.sv - frame sequencer sharing one keystream generator across R/G/B decrypt
module rx_decrypt_scheduler #(
    parameter int NUM_PIXELS = 256,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    rx_decrypt_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_READ, S_KEY_R, S_KEY_G, S_KEY_B, S_WRITE, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] pix;
    logic              sample_load;
    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] sample_g;
    logic [DATA_W-1:0] sample_b;
    logic [DATA_W-1:0] key_r;
    logic [DATA_W-1:0] key_g;

    // Frame FSM with registered outputs; the blue key byte is folded straight into wr_data_b
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            pix                <= '0;
            sample_load        <= 1'b0;
            sample_r           <= '0;
            sample_g           <= '0;
            sample_b           <= '0;
            key_r              <= '0;
            key_g              <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            bus.prng_seed_load <= 1'b0;
            bus.prng_req       <= 1'b0;
            bus.rd_en          <= 1'b0;
            bus.rd_addr        <= '0;
            bus.wr_en          <= 1'b0;
            bus.wr_addr        <= '0;
            bus.wr_data_r      <= '0;
            bus.wr_data_g      <= '0;
            bus.wr_data_b      <= '0;
        end else begin
            // strobes and their address/data are only non-zero in the cycle they are asserted
            bus.prng_seed_load <= 1'b0;
            bus.rd_en          <= 1'b0;
            bus.rd_addr        <= '0;
            bus.wr_en          <= 1'b0;
            bus.wr_addr        <= '0;
            bus.wr_data_r      <= '0;
            bus.wr_data_g      <= '0;
            bus.wr_data_b      <= '0;

            // memory data is only guaranteed in the first cycle after the read strobe
            if (sample_load) begin
                sample_r    <= bus.rd_data_r;
                sample_g    <= bus.rd_data_g;
                sample_b    <= bus.rd_data_b;
                sample_load <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state              <= S_SEED;
                        bus.prng_seed_load <= 1'b1;
                        pix                <= '0;
                        busy               <= 1'b1;
                        done               <= 1'b0;
                    end
                end
                S_SEED: begin
                    state       <= S_READ;
                    pix         <= '0;
                    bus.rd_en   <= 1'b1;
                    bus.rd_addr <= '0;
                end
                S_READ: begin
                    state        <= S_KEY_R;
                    sample_load  <= 1'b1;
                    bus.prng_req <= 1'b1;
                end
                S_KEY_R: begin
                    if (bus.prng_valid) begin
                        key_r <= bus.prng_byte;
                        state <= S_KEY_G;
                    end
                end
                S_KEY_G: begin
                    if (bus.prng_valid) begin
                        key_g <= bus.prng_byte;
                        state <= S_KEY_B;
                    end
                end
                S_KEY_B: begin
                    if (bus.prng_valid) begin
                        state         <= S_WRITE;
                        bus.prng_req  <= 1'b0;
                        bus.wr_en     <= 1'b1;
                        bus.wr_addr   <= pix;
                        bus.wr_data_r <= sample_r ^ key_r;
                        bus.wr_data_g <= sample_g ^ key_g;
                        bus.wr_data_b <= sample_b ^ bus.prng_byte;
                    end
                end
                S_WRITE: begin
                    if (pix == LAST_PIX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pix         <= pix + 1'b1;
                        state       <= S_READ;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= pix + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_decrypt_scheduler.sv
// tb/tb_rx_decrypt_scheduler.sv - scoreboard bench for rx_decrypt_scheduler
module tb_rx_decrypt_scheduler;
    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 8;
    localparam int NUM_PIXELS = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        r;
        logic [7:0]        g;
        logic [7:0]        b;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    int   checks, failures, cyc, hs, stalls, kidx, wr_cnt, done_cyc, start_cyc;
    bit   stall_mode, key_const, done_seen;
    logic [63:0] or_acc;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    rx_decrypt_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rx_decrypt_scheduler #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    // encrypted memories: R=0x10+a, G=0x20+a, B=0x30+a, one cycle read latency
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_r <= 8'h10 + 8'(bus.rd_addr);
            bus.rd_data_g <= 8'h20 + 8'(bus.rd_addr);
            bus.rd_data_b <= 8'h30 + 8'(bus.rd_addr);
        end
    end

    function automatic logic [7:0] key_fn(int n);
        if (key_const) return 8'hA5;
        return 8'(32'h3C + n * 29);
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.prng_seed_load, bus.prng_req, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr,
                    bus.wr_data_r, bus.wr_data_g, bus.wr_data_b, busy, done});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_frame();
        wr_t e;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            e.addr = ADDR_W'(i);
            e.r = (8'h10 + 8'(i)) ^ key_fn(3 * i);
            e.g = (8'h20 + 8'(i)) ^ key_fn(3 * i + 1);
            e.b = (8'h30 + 8'(i)) ^ key_fn(3 * i + 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 64'(bus.wr_addr), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_data_rgb", 64'({bus.wr_data_r, bus.wr_data_g, bus.wr_data_b}), 64'({e.r, e.g, e.b}));
            end
        end
        if (done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (bus.prng_seed_load === 1'b1) kidx = 0;
        bus.prng_valid = stall_mode ? (cyc % 3 == 0) : 1'b1;
        bus.prng_byte  = key_fn(kidx);
        if (bus.prng_req === 1'b1) begin
            if (bus.prng_valid) begin
                hs++;
                kidx++;
            end else begin
                stalls++;
            end
        end
    endtask

    task automatic start_frame();
        hs = 0; stalls = 0; wr_cnt = 0; done_seen = 1'b0;
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(done_seen), 64'd1);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; hs = 0; stalls = 0; kidx = 0; wr_cnt = 0;
        done_cyc = 0; start_cyc = 0; done_seen = 1'b0;
        stall_mode = 1'b0; key_const = 1'b1;
        rst = 1'b1; start = 1'b0;
        bus.prng_valid = 1'b0; bus.prng_byte = '0;

        // reset and idle
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", outs(), 64'd0);
        or_acc = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            or_acc |= outs();
        end
        chk("idle_outputs", or_acc, 64'd0);

        // zero-wait frame with constant keystream 0xA5
        push_frame();
        chk("addr0_expected_rgb", 64'({exp_q[0].r, exp_q[0].g, exp_q[0].b}), 64'hB58595);
        start_frame();
        chk("seed_load_latency", 64'(bus.prng_seed_load), 64'd1);
        chk("busy_in_seed", 64'(busy), 64'd1);
        tick();
        chk("first_rd_en", 64'(bus.rd_en), 64'd1);
        chk("first_rd_addr", 64'(bus.rd_addr), 64'd0);
        wait_done(200);
        chk("done_latency_zero_wait", 64'(done_cyc - start_cyc), 64'd22);
        chk("handshakes_zero_wait", 64'(hs), 64'd12);
        chk("busy_in_done", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("writes_no_extra_after_last", 64'(wr_cnt), 64'(NUM_PIXELS));
        chk("done_held", 64'(done), 64'd1);
        chk("scoreboard_empty_f1", 64'(exp_q.size()), 64'd0);

        // stalled generator, distinct key bytes to expose ordering
        key_const = 1'b0; stall_mode = 1'b1;
        push_frame();
        start_frame();
        wait_done(400);
        chk("stall_cycles_seen", 64'(stalls != 0), 64'd1);
        chk("done_latency_stalled", 64'(done_cyc - start_cyc), 64'(22 + stalls));
        chk("handshakes_stalled", 64'(hs), 64'd12);
        chk("scoreboard_empty_f2", 64'(exp_q.size()), 64'd0);

        // start while busy is ignored
        stall_mode = 1'b0;
        push_frame();
        start_frame();
        for (int i = 0; i < 8; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_no_seed", 64'(bus.prng_seed_load), 64'd0);
        chk("busy_start_still_busy", 64'(busy), 64'd1);
        wait_done(200);
        chk("done_latency_busy_start", 64'(done_cyc - start_cyc), 64'd22);
        chk("writes_busy_start", 64'(wr_cnt), 64'(NUM_PIXELS));

        // restart from DONE
        chk("done_before_restart", 64'(done), 64'd1);
        push_frame();
        start_frame();
        chk("restart_done_cleared", 64'(done), 64'd0);
        chk("restart_seed_load", 64'(bus.prng_seed_load), 64'd1);
        tick();
        chk("restart_rd_en", 64'(bus.rd_en), 64'd1);
        chk("restart_rd_addr", 64'(bus.rd_addr), 64'd0);
        wait_done(200);
        chk("writes_restart", 64'(wr_cnt), 64'(NUM_PIXELS));

        // reset in KEY_G of pixel 2
        push_frame();
        start_frame();
        begin
            int n = 0;
            while (hs < 7 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("reach_pixel2_key_r", 64'(hs >= 7), 64'd1);
        tick();
        chk("key_g_req_high", 64'(bus.prng_req), 64'd1);
        chk("key_g_writes_before_reset", 64'(wr_cnt), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_mid_outputs", outs(), 64'd0);
        exp_q.delete();
        or_acc = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            or_acc |= outs();
        end
        chk("reset_mid_stays_idle", or_acc, 64'd0);

        // fresh frame after reset rewrites from address 0
        push_frame();
        start_frame();
        tick();
        chk("post_reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        wait_done(200);
        chk("done_latency_post_reset", 64'(done_cyc - start_cyc), 64'd22);
        chk("writes_post_reset", 64'(wr_cnt), 64'(NUM_PIXELS));
        chk("scoreboard_empty_end", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
